// File: rtl/lpm_inpad_sync.sv
// Registered input-pad receiver: synchronizes an asynchronous pad bus into the
// clock domain, debounces it as a whole word and publishes a stable value plus
// one-cycle changed/rise/fall pulses.
module lpm_inpad_sync #(
  parameter int unsigned          lpm_width       = 1,
  parameter int unsigned          lpm_sync_stages = 2,
  parameter int unsigned          lpm_debounce    = 4,
  parameter logic [lpm_width-1:0] lpm_reset_value = '0,
  parameter string                lpm_type        = "lpm_inpad_sync",
  parameter string                lpm_hint        = "UNUSED"
) (
  input  logic                 clock,
  input  logic                 aclr_n,
  input  logic [lpm_width-1:0] pad,
  output logic [lpm_width-1:0] data,
  output logic                 changed,
  output logic [lpm_width-1:0] rise,
  output logic [lpm_width-1:0] fall
);

  localparam int unsigned    CntW   = $clog2(lpm_debounce + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(lpm_debounce);

  // Illegal parameter values stop elaboration, naming the offending instance.
  if (lpm_width < 1) begin : g_bad_width
    $fatal(1, "lpm_inpad_sync: lpm_width must be >= 1 in %m");
  end
  if (lpm_sync_stages < 2) begin : g_bad_stages
    $fatal(1, "lpm_inpad_sync: lpm_sync_stages must be >= 2 in %m");
  end
  if (lpm_debounce < 1) begin : g_bad_debounce
    $fatal(1, "lpm_inpad_sync: lpm_debounce must be >= 1 in %m");
  end
  if (lpm_type == "" || lpm_hint == "") begin : g_bad_strings
    $fatal(1, "lpm_inpad_sync: lpm_type and lpm_hint must be non-empty in %m");
  end

  logic [lpm_width-1:0] sync_q [lpm_sync_stages];
  logic [lpm_width-1:0] sync_out;

  logic [lpm_width-1:0] prev_q, prev_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 upd;

  logic [lpm_width-1:0] data_q, data_d;
  logic                 changed_q, changed_d;
  logic [lpm_width-1:0] rise_q, rise_d;
  logic [lpm_width-1:0] fall_q, fall_d;

  assign sync_out = sync_q[lpm_sync_stages-1];

  // Plain flop chain for metastability settling; nothing may sit between stages.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int unsigned i = 0; i < lpm_sync_stages; i++) begin
        sync_q[i] <= lpm_reset_value;
      end
    end else begin
      sync_q[0] <= pad;
      for (int unsigned i = 1; i < lpm_sync_stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Stability tracking and update decision; any bit change restarts the whole word.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (sync_out != prev_q) begin
      prev_d = sync_out;
      cnt_d  = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end

    // Saturated count alone is not enough: a value that returns to data is ignored.
    upd       = (cnt_q == CntMax) && (prev_q != data_q);
    data_d    = upd ? prev_q : data_q;
    changed_d = upd;
    rise_d    = upd ? (prev_q & ~data_q) : '0;
    fall_d    = upd ? (~prev_q & data_q) : '0;
  end

  // Tracker, published word and pulse registers.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      prev_q    <= lpm_reset_value;
      cnt_q     <= '0;
      data_q    <= lpm_reset_value;
      changed_q <= 1'b0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      changed_q <= changed_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign data    = data_q;
  assign changed = changed_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: tb/tb_lpm_inpad_sync.sv
// Bench for lpm_inpad_sync (8-bit, 2 sync stages, debounce 4, reset value 0).
// Each stimulus step that must produce an update pushes the expected edge and
// outputs; a negedge monitor pops and compares whenever changed fires or the
// expected edge is reached.
module tb_lpm_inpad_sync;

  localparam int unsigned Latency = 7;  // S + D + 1 edges from pad change to data

  logic       clock;
  logic       aclr_n;
  logic [7:0] pad;
  logic [7:0] data;
  logic       changed;
  logic [7:0] rise;
  logic [7:0] fall;

  typedef struct {
    int unsigned edge_no;
    logic [7:0]  d;
    logic [7:0]  r;
    logic [7:0]  f;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_data;
  int unsigned edge_n;
  int          checks;
  int          errors;

  lpm_inpad_sync #(
    .lpm_width      (8),
    .lpm_sync_stages(2),
    .lpm_debounce   (4),
    .lpm_reset_value(8'h00)
  ) dut (
    .clock  (clock),
    .aclr_n (aclr_n),
    .pad    (pad),
    .data   (data),
    .changed(changed),
    .rise   (rise),
    .fall   (fall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
    end
  endtask

  task automatic expect_update(input logic [7:0] d);
    exp_t e;
    e.edge_no = edge_n + Latency;
    e.d       = d;
    e.r       = d & ~exp_data_pending();
    e.f       = ~d & exp_data_pending();
    sb.push_back(e);
  endtask

  // Value data will hold once every queued update has landed.
  function automatic logic [7:0] exp_data_pending();
    if (sb.size() == 0) return exp_data;
    return sb[sb.size()-1].d;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (!aclr_n) begin
      check("rst_data", data, 8'h00);
      check("rst_changed", changed, 0);
      check("rst_rise", rise, 8'h00);
      check("rst_fall", fall, 8'h00);
    end else begin
      if (sb.size() == 0) begin
        check("idle_changed", changed, 0);
      end else if (changed || edge_n >= sb[0].edge_no) begin
        e = sb.pop_front();
        check("upd_edge", edge_n, e.edge_no);
        check("upd_changed", changed, 1);
        check("upd_data", data, e.d);
        check("upd_rise", rise, e.r);
        check("upd_fall", fall, e.f);
        exp_data = e.d;
      end
      check("data_hold", data, exp_data);
      check("rf_iff_changed", ((rise | fall) != 8'h00), changed);
      check("rf_overlap", rise & fall, 8'h00);
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    edge_n   = 0;
    exp_data = 8'h00;
    aclr_n   = 1'b0;
    pad      = 8'hA5;

    // Reset with a busy pad, then release onto the reset value: no pulse expected.
    cycles(4);
    pad = 8'h00;
    cycles(1);
    aclr_n = 1'b1;
    cycles(20);

    // Glitch of 3 synchronized cycles never reaches data.
    pad = 8'h01;
    cycles(3);
    pad = 8'h00;
    cycles(12);

    // Clean step.
    expect_update(8'h3C);
    pad = 8'h3C;
    cycles(12);

    // Bit0 toggling every 3 cycles keeps restarting the count.
    for (int i = 0; i < 10; i++) begin
      pad = pad ^ 8'h01;
      cycles(3);
    end
    expect_update(8'h3D);
    pad = 8'h3D;
    cycles(15);

    // Mixed edges: go to F0, then flip every bit to 0F.
    expect_update(8'hF0);
    pad = 8'hF0;
    cycles(12);
    expect_update(8'h0F);
    pad = 8'h0F;
    cycles(12);

    // Reset mid-count: step to FF, assert reset when cnt is 2.
    pad = 8'hFF;
    @(posedge clock);  // edge 1: first sync stage
    @(posedge clock);  // edge 2: sync_out
    @(posedge clock);  // edge 3: cnt=1
    @(posedge clock);  // edge 4: cnt=2
    #2;
    aclr_n = 1'b0;
    sb.delete();
    exp_data = 8'h00;
    #1;
    check("async_clr_data", data, 8'h00);
    check("async_clr_changed", changed, 0);
    check("async_clr_rise", rise, 8'h00);
    cycles(3);
    aclr_n = 1'b1;
    expect_update(8'hFF);
    cycles(25);

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
